// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Definitions shared by the load/store unit and its helpers:
//   - RV32I funct3 encodings for loads and stores
//   - FSM state encoding
//   - helpers for the byte count and funct3 legality of a request
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } lsu_state_t;

    // Number of byte accesses for an access size; only funct3[1:0] selects size.
    function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
        logic [2:0] n;
        case (f3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Stores only exist as B/H/W; loads add the unsigned B/H forms.
    function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
        logic ok;
        if (is_write)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the core-side request/response signals and the byte-wide
// data_memory port of the load/store unit.
//   core side  : req_valid, req_write, req_funct3, req_addr, req_wdata ->
//                busy, done, error, rdata
//   memory side: mem_address, mem_write_data, mem_write_enable,
//                mem_read_enable -> mem_read_data (one-cycle read latency)
// Modports:
//   slave  - the load/store unit itself
//   master - the environment (core + data_memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [XLEN-1:0]       req_wdata;

    logic                  busy;
    logic                  done;
    logic                  error;
    logic [XLEN-1:0]       rdata;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_write_data;
    logic                  mem_write_enable;
    logic                  mem_read_enable;
    logic [7:0]            mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output busy, done, error, rdata,
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  busy, done, error, rdata,
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of an assembled little-endian load.
// Ports:
//   i_bytes  [31:0] - assembled load bytes, byte 0 in bits [7:0]
//   i_funct3 [2:0]  - load funct3 (B, H, W, BU, HU)
//   o_rdata  [31:0] - extended result; W and unknown codes pass through
// ---------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_rdata = i_bytes;
        case (i_funct3)
            F3_B:    o_rdata = {{24{i_bytes[7]}},  i_bytes[7:0]};
            F3_H:    o_rdata = {{16{i_bytes[15]}}, i_bytes[15:0]};
            F3_BU:   o_rdata = {24'd0, i_bytes[7:0]};
            F3_HU:   o_rdata = {16'd0, i_bytes[15:0]};
            default: o_rdata = i_bytes;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns one RV32I load/store into 1, 2 or 4 little-endian byte accesses on a
// byte-wide data memory, assembles and extends load data, and holds the core
// off with busy until the done pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - load_store_unit_if.slave: request/response and memory port
// Configuration macro:
//   LSU_ALLOW_MISALIGNED_EN - when defined, misaligned H/W accesses run
//   byte-by-byte instead of being rejected; error then flags only an
//   illegal funct3.
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    lsu_state_t            r_state;
    lsu_state_t            w_state_next;

    // control
    logic [1:0]            r_idx;          // byte currently being issued
    logic                  r_err;
    logic                  r_rd_vld_p1;    // a read was issued last cycle

    // latched request
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_last_idx;
    logic [XLEN-1:0]       r_wdata_sh;     // store bytes still to be sent
    logic [1:0]            r_rd_idx_p1;    // byte slot of the read in flight
    logic [XLEN-1:0]       r_bytes;        // load bytes captured so far

    // registered outputs
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [7:0]            r_mem_wdata;
    logic [XLEN-1:0]       r_rdata;

    logic                  w_f3_ok;
    logic                  w_aligned;
    logic                  w_req_ok;
    logic                  w_accept;
    logic                  w_last_issue;
    logic [XLEN-1:0]       w_assembled;
    logic [XLEN-1:0]       w_extended;

    assign w_f3_ok = f3_legal(bus.req_write, bus.req_funct3);

`ifdef LSU_ALLOW_MISALIGNED_EN
    assign w_aligned = 1'b1;
`else
    always_comb begin
        w_aligned = 1'b1;
        case (bus.req_funct3[1:0])
            2'b01:   w_aligned = ~bus.req_addr[0];
            2'b10:   w_aligned = (bus.req_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end
`endif

    assign w_req_ok     = w_f3_ok & w_aligned;
    assign w_accept     = (r_state == ST_IDLE) & bus.req_valid;
    assign w_last_issue = (r_idx == r_last_idx);

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // ---- FSM: next state and control outputs ----
    always_comb begin
        w_state_next         = r_state;
        bus.busy             = 1'b1;
        bus.done             = 1'b0;
        bus.error            = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_read_enable  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                // Rejected requests go straight to FIN so done/error pulse
                // in the very next cycle without touching memory.
                if (bus.req_valid)
                    w_state_next = w_req_ok ? ST_ISSUE : ST_FIN;
            end
            ST_ISSUE: begin
                bus.mem_write_enable = r_write;
                bus.mem_read_enable  = ~r_write;
                if (w_last_issue)
                    w_state_next = r_write ? ST_FIN : ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_next = ST_FIN;
            end
            ST_FIN: begin
                bus.done     = 1'b1;
                bus.error    = r_err;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---- issue stage: control and memory-port registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= 2'd0;
            r_err         <= 1'b0;
            r_rd_vld_p1   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= 8'd0;
            r_rdata       <= '0;
        end else begin
            r_rd_vld_p1 <= (r_state == ST_ISSUE) & ~r_write;
            if (w_accept) begin
                r_idx <= 2'd0;
                r_err <= ~w_req_ok;
                // The first byte is presented straight from the request so
                // it is on the bus in the first ISSUE cycle.
                if (w_req_ok) begin
                    r_mem_address <= bus.req_addr;
                    if (bus.req_write)
                        r_mem_wdata <= bus.req_wdata[7:0];
                end
            end else if ((r_state == ST_ISSUE) && !w_last_issue) begin
                r_idx         <= r_idx + 2'd1;
                r_mem_address <= r_mem_address + ADDR_ONE;
                if (r_write)
                    r_mem_wdata <= r_wdata_sh[7:0];
            end
            // The final byte arrives during DRAIN; extend it together with
            // the earlier bytes so rdata is ready in the FIN cycle.
            if (r_state == ST_DRAIN)
                r_rdata <= w_extended;
        end
    end

    // ---- issue stage: latched request data ----
    always_ff @(posedge clk) begin
        r_rd_idx_p1 <= r_idx;
        if (w_accept) begin
            r_write    <= bus.req_write;
            r_funct3   <= bus.req_funct3;
            r_last_idx <= 2'(f3_nbytes(bus.req_funct3) - 3'd1);
            r_wdata_sh <= bus.req_wdata >> 8;
            r_bytes    <= '0;
        end else begin
            if ((r_state == ST_ISSUE) && !w_last_issue && r_write)
                r_wdata_sh <= r_wdata_sh >> 8;
            if (r_rd_vld_p1)
                r_bytes <= w_assembled;
        end
    end

    // ---- capture stage: merge the returning byte into its slot ----
    always_comb begin
        w_assembled = r_bytes;
        case (r_rd_idx_p1)
            2'd0:    w_assembled[7:0]   = bus.mem_read_data;
            2'd1:    w_assembled[15:8]  = bus.mem_read_data;
            2'd2:    w_assembled[23:16] = bus.mem_read_data;
            default: w_assembled[31:24] = bus.mem_read_data;
        endcase
    end

    load_extend u_load_extend (
        .i_bytes  (w_assembled),
        .i_funct3 (r_funct3),
        .o_rdata  (w_extended)
    );

    assign bus.rdata          = r_rdata;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench for load_store_unit: the stimulus process predicts every
// memory access and completion from a byte-array model of memory and pushes
// them into queues; a monitor on the falling edge pops and compares whenever
// the DUT presents a write, read or done. Honours LSU_ALLOW_MISALIGNED_EN.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(32), .XLEN(32)) bus();

    load_store_unit #(.ADDR_WIDTH(32), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { bit err; logic [31:0] rdata; int cyc; } done_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic [31:0] addr; int cyc; } rd_t;

    done_t dq[$];
    wr_t   wq[$];
    rd_t   rq[$];

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          inflight = 0;
    logic [31:0] model_rdata = 32'd0;
    logic [7:0]  ref_mem [256];
    logic [7:0]  dut_mem [256];
    bit          mem_inited = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // data_memory stand-in: one-cycle read latency, 256 bytes aliased on addr[7:0]
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) dut_mem[i] <= init_byte(i);
            bus.mem_read_data <= 8'd0;
            mem_inited <= 1'b1;
        end else begin
            if (bus.mem_write_enable) dut_mem[bus.mem_address[7:0]] <= bus.mem_write_data;
            if (bus.mem_read_enable)  bus.mem_read_data <= dut_mem[bus.mem_address[7:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT activity with nothing expected (t=%0t)", name, $time);
    endtask

    // ---- monitor ----
    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 32'(bus.busy), 32'(inflight != 0));
            if (bus.mem_write_enable) begin
                if (wq.size() == 0) unexpected("mem_write");
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", bus.mem_address, w.addr);
                    check("wr_data", 32'(bus.mem_write_data), 32'(w.data));
                    check("wr_cycle", cyc, w.cyc);
                end
            end
            if (bus.mem_read_enable) begin
                if (rq.size() == 0) unexpected("mem_read");
                else begin
                    rd_t r;
                    r = rq.pop_front();
                    check("rd_addr", bus.mem_address, r.addr);
                    check("rd_cycle", cyc, r.cyc);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) unexpected("done");
                else begin
                    done_t d;
                    d = dq.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("error", 32'(bus.error), 32'(d.err));
                    check("rdata", bus.rdata, d.rdata);
                    inflight--;
                end
            end else begin
                check("error_without_done", 32'(bus.error), 32'd0);
            end
        end
    end

    // ---- stimulus + reference model ----
    task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit keep = 1'b0,
                         input int max_wr = 4, input bit expect_done = 1'b1);
        int          guard;
        int          acc;
        int          n;
        bit          legal;
        bit          aligned;
        logic [31:0] val;
        logic [31:0] ak;
        byte         sb;
        shortint     sh;
        done_t       d;
        guard = 0;
        @(negedge clk);
        while (bus.busy) begin
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL idle_wait: busy=%0b still high, required 0", bus.busy);
                return;
            end
            @(negedge clk);
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
        acc = cyc;

        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_ALLOW_MISALIGNED_EN
        aligned = 1'b1;
`else
        aligned = (a % n) == 0;
`endif
        d.err   = 1'b0;
        d.rdata = model_rdata;
        if (!(legal && aligned)) begin
            d.err = 1'b1;
            d.cyc = acc;
        end else if (w) begin
            for (int k = 0; k < n; k++) begin
                if (k < max_wr) begin
                    ak = a + 32'(k);
                    wq.push_back('{addr: ak, data: wd[8*k +: 8], cyc: acc + k});
                    ref_mem[ak[7:0]] = wd[8*k +: 8];
                end
            end
            d.cyc = acc + n;
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++) begin
                ak = a + 32'(k);
                rq.push_back('{addr: ak, cyc: acc + k});
                val = val | (32'(ref_mem[ak[7:0]]) << (8 * k));
            end
            case (f3)
                3'd0: begin sb = val[7:0];  val = 32'(int'(sb)); end
                3'd1: begin sh = val[15:0]; val = 32'(int'(sh)); end
                3'd4: val = val & 32'h0000_00FF;
                3'd5: val = val & 32'h0000_FFFF;
                default: ;
            endcase
            model_rdata = val;
            d.rdata = val;
            d.cyc   = acc + n + 1;
        end
        inflight++;
        if (expect_done) dq.push_back(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
        check({tag, "_maddr"}, bus.mem_address, 32'd0);
        check({tag, "_mwdata"}, 32'(bus.mem_write_data), 32'd0);
        check({tag, "_mwe"},   32'(bus.mem_write_enable), 32'd0);
        check({tag, "_mre"},   32'(bus.mem_read_enable), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // directed
        issue(1'b1, F3_W,  32'h4, 32'hDEADBEEF);
        issue(1'b0, F3_B,  32'h7, 32'h0);
        issue(1'b0, F3_BU, 32'h7, 32'h0);
        issue(1'b0, F3_H,  32'h4, 32'h0);
        issue(1'b0, F3_W,  32'h4, 32'h0);
        issue(1'b0, F3_W,  32'h5, 32'h0);
        issue(1'b1, 3'd4,  32'h8, 32'h12345678);
        issue(1'b0, 3'd3,  32'h8, 32'h0);
        issue(1'b1, F3_H,  32'hFFFF_FFFE, 32'hCAFE_A55A);
        issue(1'b0, F3_HU, 32'hFFFF_FFFE, 32'h0);

        // randomized
        for (int i = 0; i < 160; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 47));
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // reset during the second byte of a word store
        issue(1'b1, F3_W, 32'h10, 32'hA1B2C3D4, 1'b0, 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        inflight    = 0;
        model_rdata = 32'd0;
        reset       = 1'b0;
        issue(1'b0, F3_W, 32'h10, 32'h0);

        // request held valid through busy, then back-to-back requests
        issue(1'b0, F3_W, 32'h20, 32'h0, 1'b1);
        issue(1'b1, F3_H, 32'h22, 32'h0000_9876, 1'b1);
        issue(1'b0, F3_H, 32'h22, 32'h0, 1'b0);

        begin
            int guard;
            guard = 0;
            while (inflight != 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        @(negedge clk);
        check("pending_done",  32'(dq.size()), 32'd0);
        check("pending_write", 32'(wq.size()), 32'd0);
        check("pending_read",  32'(rq.size()), 32'd0);
        for (int i = 0; i < 256; i++) check("mem_contents", 32'(dut_mem[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/memory stage and the byte-wide data_memory.
- Converts one RV32I load/store (LB/LH/LW/LBU/LHU, SB/SH/SW) into a sequence of 1, 2 or 4 byte accesses on data_memory's 8-bit port, in little-endian order.
- Assembles load bytes and applies sign or zero extension.
- Holds the core stalled via busy until done.

Parameters:
- ADDR_WIDTH, 32, width of the CPU address and the memory address.
- XLEN, 32, CPU data width; bytes per word = XLEN/8.

Ports:
- clk  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe; sampled only while busy=0.
- req_write  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I funct3; size and signedness.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  XLEN  store data; LSBs used for SB/SH.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; operation complete.
- error  output  1  one-cycle pulse coincident with done; misaligned or illegal funct3.
- rdata  output  XLEN  extended load result; valid at done, held until the next accepted load.
- mem_address  output  ADDR_WIDTH  to data_memory address.
- mem_write_data  output  8  to data_memory write_data.
- mem_write_enable  output  1  to data_memory write_enable.
- mem_read_enable  output  1  to data_memory read_enable.
- mem_read_data  input  8  from data_memory read_data; valid one cycle after the read_enable/address cycle.

Behaviour:
- Reset values: busy=0, done=0, error=0, rdata=0, mem_address=0, mem_write_data=0, mem_write_enable=0, mem_read_enable=0. FSM goes to IDLE.
- States: IDLE, ISSUE, DRAIN, FIN.
- Acceptance and byte count:
  - A request is accepted at edge t when state=IDLE and req_valid=1. Address, data, funct3 and direction are latched.
  - N = 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
- Legality:
  - Legal load funct3 values: 0, 1, 2, 4, 5. Legal store funct3 values: 0, 1, 2.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - Illegal or misaligned request: IDLE->FIN with no memory enable asserted. done=error=1 in cycle t+1. rdata is unchanged.
- ISSUE: byte k (k=0..N-1) drives mem_address = addr+k during cycle t+1+k.
  - Store: mem_write_data = wdata[8k+7:8k], mem_write_enable=1.
  - Load: mem_read_enable=1.
- Load capture:
  - Reads are pipelined: byte k is captured from mem_read_data at the end of cycle t+2+k.
  - After the last issue, a load goes to DRAIN for one cycle to capture the final byte.
- Timing:
  - Store: ISSUE->FIN after byte N-1. done in cycle t+1+N.
  - Load: ISSUE->DRAIN->FIN. done in cycle t+2+N, with rdata already extended in that cycle.
- Extension:
  - funct3 0 sign-extends from bit 7; funct3 1 sign-extends from bit 15.
  - funct3 4 and 5 zero-extend. LW is passed unchanged.
- FIN->IDLE unconditionally. busy=0 in IDLE only, so busy is high in cycles t+1 through the done cycle inclusive.
- Enables are deasserted in every state except ISSUE. mem_address and mem_write_data hold their last values.
- req_valid while busy=1 is ignored; no queueing.
- A new request may be accepted at the edge ending the FIN cycle, because the FSM is then in IDLE.
- Address increment wraps modulo 2^ADDR_WIDTH. This only matters with the optional feature enabled.
- Reset mid-operation aborts the access: all outputs return to reset values at that edge, and remaining bytes are not written (partial store permitted).

Optional Feature:
- Macro: LSU_ALLOW_MISALIGNED_EN.
- Defined: alignment checks are removed. Misaligned halfword/word accesses execute byte-by-byte at addr..addr+N-1 with normal timing. error flags only illegal funct3.
- Undefined: misaligned accesses produce error as specified above.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - FSM state encoding.
  - Function returning byte count from funct3.
- One sub-module: load_extend. Combinational; inputs are the assembled 32-bit bytes and funct3; output is the extended rdata.

Test Plan:
- SW addr=0x4, wdata=0xDEADBEEF -> writes EF@4, BE@5, AD@6, DE@7 in cycles t+1..t+4; done in t+5; error=0.
- LB addr=0x7 after the SW -> rdata=0xFFFFFFDE, done in t+3. LBU addr=0x7 -> 0x000000DE.
- LH addr=0x4 -> 0xFFFFBEEF, done in t+4. LW addr=0x4 -> 0xDEADBEEF, done in t+6.
- LW addr=0x5 with macro undefined -> done=error=1 in t+1, no enables asserted, rdata unchanged. Same with macro defined -> 0xXXDEADBE (byte 8 content) with error=0.
- Store with funct3=4, and load with funct3=3 -> error=1 in t+1, no memory access.
- Reset asserted during cycle t+2 of an SW -> exactly 2 bytes written. Outputs read 0 after the reset edge. busy=0. The next request is accepted normally.
- req_valid held high during busy -> exactly one access sequence. A back-to-back request is accepted at the edge ending the FIN cycle.
